// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the 5-stage LoongArch core.
// Latches the EXE->MEM payload, selects and extends load data from the
// data-SRAM response, holds that response across WB back-pressure, and
// publishes a forwarding bus to ID.
module mem_stage #(
    parameter int IN_BUS_W  = 103,
    parameter int OUT_BUS_W = 102
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_to_MEM_valid,
    input  logic [IN_BUS_W-1:0]  EXE_to_MEM_bus,
    output logic                 MEM_allow_in,
    input  logic [31:0]          data_sram_rdata,
    output logic                 MEM_to_WB_valid,
    input  logic                 WB_allow_in,
    output logic [OUT_BUS_W-1:0] MEM_to_WB_bus,
    output logic [37:0]          MEM_wr_bus
);

    // Load opcodes, taken from inst[31:22].
    localparam logic [9:0] OP_LD_B  = 10'h0a0;
    localparam logic [9:0] OP_LD_H  = 10'h0a1;
    localparam logic [9:0] OP_LD_W  = 10'h0a2;
    localparam logic [9:0] OP_LD_BU = 10'h0a8;
    localparam logic [9:0] OP_LD_HU = 10'h0a9;

    typedef enum logic [2:0] {
        LK_W,
        LK_B,
        LK_H,
        LK_BU,
        LK_HU
    } load_kind_e;

    // Pipeline state.
    logic                r_mem_valid;
    logic [IN_BUS_W-1:0] r_bus;
    logic [31:0]         r_rdata_buf;
    logic                r_buf_vld;

    // Fields of the latched EXE payload.
    logic [31:0] w_alu_result;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_pc;
    logic [31:0] w_inst;

    logic        w_ready_go;
    logic [31:0] w_eff_rdata;
    load_kind_e  w_load_kind;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;
    logic [31:0] w_final_result;

    assign w_alu_result   = r_bus[102:71];
    assign w_res_from_mem = r_bus[70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_pc           = r_bus[63:32];
    assign w_inst         = r_bus[31:0];

    // MEM never needs more than one cycle.
    assign w_ready_go      = 1'b1;
    assign MEM_allow_in    = ~r_mem_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_mem_valid & w_ready_go;

    // Valid bit advances whenever MEM can accept; a bubble in clears it.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            r_mem_valid <= EXE_to_MEM_valid;
        end
    end

    // Payload latch only loads on a real transfer, so bubbles keep old contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus <= '0;
        end else if (EXE_to_MEM_valid && MEM_allow_in) begin
            r_bus <= EXE_to_MEM_bus;
        end
    end

    // Hold the SRAM response while WB stalls; release it when the load leaves.
    // NOTE: the buffer is reset like any other flop so a reset mid-stall can
    // never let stale data leak into the next instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_buf <= 32'h0;
            r_buf_vld   <= 1'b0;
        end else if (r_mem_valid && WB_allow_in) begin
            r_buf_vld <= 1'b0;
        end else if (r_mem_valid && !r_buf_vld && !WB_allow_in) begin
            r_rdata_buf <= data_sram_rdata;
            r_buf_vld   <= 1'b1;
        end
    end

    assign w_eff_rdata = r_buf_vld ? r_rdata_buf : data_sram_rdata;

    // Classify the load; unknown opcodes with res_from_mem behave as ld.w.
    // NOTE: every always_comb output gets a default first so no path can
    // infer a latch.
    always_comb begin
        w_load_kind = LK_W;
        case (w_inst[31:22])
            OP_LD_B:  w_load_kind = LK_B;
            OP_LD_H:  w_load_kind = LK_H;
            OP_LD_W:  w_load_kind = LK_W;
            OP_LD_BU: w_load_kind = LK_BU;
            OP_LD_HU: w_load_kind = LK_HU;
            default:  w_load_kind = LK_W;
        endcase
    end

    // Pick the addressed byte and halfword; halfword ignores address bit 0.
    always_comb begin
        w_byte = w_eff_rdata[7:0];
        case (w_alu_result[1:0])
            2'd0: w_byte = w_eff_rdata[7:0];
            2'd1: w_byte = w_eff_rdata[15:8];
            2'd2: w_byte = w_eff_rdata[23:16];
            2'd3: w_byte = w_eff_rdata[31:24];
            default: w_byte = w_eff_rdata[7:0];
        endcase
        w_half = w_alu_result[1] ? w_eff_rdata[31:16] : w_eff_rdata[15:0];
    end

    // Extend the selected data to 32 bits according to the load kind.
    always_comb begin
        w_load_value = w_eff_rdata;
        case (w_load_kind)
            LK_B:    w_load_value = {{24{w_byte[7]}}, w_byte};
            LK_BU:   w_load_value = {24'h0, w_byte};
            LK_H:    w_load_value = {{16{w_half[15]}}, w_half};
            LK_HU:   w_load_value = {16'h0, w_half};
            default: w_load_value = w_eff_rdata;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_value : w_alu_result;

    assign MEM_to_WB_bus = {w_final_result, w_gr_we, w_dest, w_pc, w_inst};

    // Write-enable is qualified by valid so a stale latched gr_we never forwards.
    assign MEM_wr_bus = {w_gr_we & r_mem_valid, w_dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected WB payloads are
// queued when an instruction is issued and compared when MEM hands it to WB.
module tb_mem_stage;

    localparam int IN_BUS_W  = 103;
    localparam int OUT_BUS_W = 102;

    logic                 clk;
    logic                 resetn;
    logic                 EXE_to_MEM_valid;
    logic [IN_BUS_W-1:0]  EXE_to_MEM_bus;
    logic                 MEM_allow_in;
    logic [31:0]          data_sram_rdata;
    logic                 MEM_to_WB_valid;
    logic                 WB_allow_in;
    logic [OUT_BUS_W-1:0] MEM_to_WB_bus;
    logic [37:0]          MEM_wr_bus;

    int n_pass  = 0;
    int n_total = 0;

    logic [OUT_BUS_W-1:0] sb_q[$];
    logic [OUT_BUS_W-1:0] mon_exp;

    typedef struct {
        logic [9:0]  op;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] res;
    } ld_vec_t;

    mem_stage #(.IN_BUS_W(IN_BUS_W), .OUT_BUS_W(OUT_BUS_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .EXE_to_MEM_bus   (EXE_to_MEM_bus),
        .MEM_allow_in     (MEM_allow_in),
        .data_sram_rdata  (data_sram_rdata),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .WB_allow_in      (WB_allow_in),
        .MEM_to_WB_bus    (MEM_to_WB_bus),
        .MEM_wr_bus       (MEM_wr_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IN_BUS_W-1:0] mk_in(logic [31:0] alu, logic rfm, logic we,
                                                 logic [4:0] dest, logic [31:0] pc,
                                                 logic [31:0] inst);
        return {alu, rfm, we, dest, pc, inst};
    endfunction

    function automatic logic [OUT_BUS_W-1:0] mk_out(logic [31:0] res, logic we, logic [4:0] dest,
                                                   logic [31:0] pc, logic [31:0] inst);
        return {res, we, dest, pc, inst};
    endfunction

    // Drive one cycle's inputs (just after a rising edge) and move to the falling edge.
    task automatic cyc_begin(input logic v, input logic [IN_BUS_W-1:0] bus,
                             input logic [31:0] rd, input logic wb);
        EXE_to_MEM_valid = v;
        EXE_to_MEM_bus   = bus;
        data_sram_rdata  = rd;
        WB_allow_in      = wb;
        @(negedge clk);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every instruction handed to WB must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && MEM_to_WB_valid && WB_allow_in) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got %h required <nothing queued>", MEM_to_WB_bus);
            end else begin
                mon_exp = sb_q.pop_front();
                if (MEM_to_WB_bus !== mon_exp)
                    $display("FAIL sb_wb_bus: got %h required %h", MEM_to_WB_bus, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        resetn           = 1'b0;
        EXE_to_MEM_valid = 1'b0;
        EXE_to_MEM_bus   = '0;
        data_sram_rdata  = 32'h0;
        WB_allow_in      = 1'b1;
        #1;
        n_total += 3;
        if (MEM_allow_in !== 1'b1) $display("FAIL rst_allow_in: got %b required 1", MEM_allow_in);
        else n_pass++;
        if (MEM_to_WB_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", MEM_to_WB_valid);
        else n_pass++;
        if (MEM_wr_bus !== 38'h0) $display("FAIL rst_wr_bus: got %h required 0", MEM_wr_bus);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc_end();
        cyc_begin(1'b0, '0, 32'h0, 1'b1);
        n_total += 3;
        if (MEM_allow_in !== 1'b1) $display("FAIL idle_allow_in: got %b required 1", MEM_allow_in);
        else n_pass++;
        if (MEM_to_WB_valid !== 1'b0) $display("FAIL idle_valid: got %b required 0", MEM_to_WB_valid);
        else n_pass++;
        if (MEM_wr_bus !== 38'h0) $display("FAIL idle_wr_bus: got %h required 0", MEM_wr_bus);
        else n_pass++;
        cyc_end();
    endtask

    // Loads issued back to back; each one's rdata arrives in its MEM cycle.
    task automatic test_back_to_back_loads();
        ld_vec_t vec[9];
        logic [31:0] inst;
        logic [31:0] pc;
        vec[0] = '{10'h0a0, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vec[1] = '{10'h0a8, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vec[2] = '{10'h0a1, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001};
        vec[3] = '{10'h0a9, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001};
        vec[4] = '{10'h0a2, 32'h0000_2002, 32'h8001_7FFF, 32'h8001_7FFF};
        vec[5] = '{10'h0a0, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F};
        vec[6] = '{10'h0a1, 32'h0000_0001, 32'h1234_ABCD, 32'hFFFF_ABCD};
        vec[7] = '{10'h0a8, 32'h0000_0001, 32'h0000_F100, 32'h0000_00F1};
        vec[8] = '{10'h0a4, 32'h0000_0003, 32'hCAFE_F00D, 32'hCAFE_F00D};
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                inst = {vec[i].op, 22'(i)};
                pc   = 32'h1c00_0000 + 32'(4 * i);
                sb_q.push_back(mk_out(vec[i].res, 1'b1, 5'(i + 1), pc, inst));
                cyc_begin(1'b1, mk_in(vec[i].alu, 1'b1, 1'b1, 5'(i + 1), pc, inst),
                          (i > 0) ? vec[i-1].rd : 32'h0, 1'b1);
            end else begin
                cyc_begin(1'b0, '0, vec[8].rd, 1'b1);
            end
            n_total++;
            if (MEM_allow_in !== 1'b1) $display("FAIL b2b_allow_in[%0d]: got %b required 1", i, MEM_allow_in);
            else n_pass++;
            cyc_end();
        end
        cyc_begin(1'b0, '0, 32'h0, 1'b1);
        cyc_end();
    endtask

    // ld.w stalled three cycles by WB; SRAM data changes but the output must not.
    task automatic test_wb_stall();
        logic [31:0] inst_w;
        logic [31:0] inst_b;
        logic [OUT_BUS_W-1:0] exp_w;
        inst_w = {10'h0a2, 22'h0_1111};
        inst_b = {10'h0a0, 22'h0_2222};
        exp_w  = mk_out(32'hDEAD_BEEF, 1'b1, 5'd3, 32'h1c00_0100, inst_w);
        sb_q.push_back(exp_w);
        cyc_begin(1'b1, mk_in(32'h0000_4000, 1'b1, 1'b1, 5'd3, 32'h1c00_0100, inst_w), 32'h0, 1'b1);
        cyc_end();
        for (int c = 0; c < 3; c++) begin
            cyc_begin(1'b0, '0, (c == 0) ? 32'hDEAD_BEEF : 32'h0, 1'b0);
            n_total += 3;
            if (MEM_allow_in !== 1'b0) $display("FAIL stall_allow_in[%0d]: got %b required 0", c, MEM_allow_in);
            else n_pass++;
            if (MEM_to_WB_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b required 1", c, MEM_to_WB_valid);
            else n_pass++;
            if (MEM_to_WB_bus !== exp_w) $display("FAIL stall_hold[%0d]: got %h required %h", c, MEM_to_WB_bus, exp_w);
            else n_pass++;
            cyc_end();
        end
        // WB frees up; a new ld.b enters in the same edge the stalled load leaves.
        sb_q.push_back(mk_out(32'hFFFF_FFAB, 1'b1, 5'd4, 32'h1c00_0104, inst_b));
        cyc_begin(1'b1, mk_in(32'h0000_5000, 1'b1, 1'b1, 5'd4, 32'h1c00_0104, inst_b), 32'h0, 1'b1);
        n_total++;
        if (MEM_allow_in !== 1'b1) $display("FAIL leave_allow_in: got %b required 1", MEM_allow_in);
        else n_pass++;
        cyc_end();
        cyc_begin(1'b0, '0, 32'h0000_00AB, 1'b1);
        cyc_end();
        cyc_begin(1'b0, '0, 32'h0, 1'b1);
        n_total++;
        if (MEM_to_WB_valid !== 1'b0) $display("FAIL drained_valid: got %b required 0", MEM_to_WB_valid);
        else n_pass++;
        cyc_end();
    endtask

    // Non-load result forwards with gr_we; the following bubble must drop gr_we.
    task automatic test_alu_forward();
        logic [31:0] inst;
        inst = 32'h0010_1CE7;
        sb_q.push_back(mk_out(32'h0000_0042, 1'b1, 5'd7, 32'h1c00_0200, inst));
        cyc_begin(1'b1, mk_in(32'h0000_0042, 1'b0, 1'b1, 5'd7, 32'h1c00_0200, inst), 32'h0, 1'b1);
        cyc_end();
        cyc_begin(1'b0, '0, 32'hFFFF_FFFF, 1'b1);
        n_total++;
        if (MEM_wr_bus !== {1'b1, 5'd7, 32'h0000_0042})
            $display("FAIL fwd_wr_bus: got %h required %h", MEM_wr_bus, {1'b1, 5'd7, 32'h0000_0042});
        else n_pass++;
        cyc_end();
        cyc_begin(1'b0, '0, 32'h0, 1'b1);
        n_total++;
        if (MEM_wr_bus[37] !== 1'b0) $display("FAIL bubble_we: got %b required 0", MEM_wr_bus[37]);
        else n_pass++;
        cyc_end();
    endtask

    // Async reset during a stall with the buffer full, then a fresh load.
    task automatic test_reset_mid_stall();
        logic [31:0] inst;
        inst = {10'h0a2, 22'h0_3333};
        sb_q.push_back(mk_out(32'h1111_2222, 1'b1, 5'd9, 32'h1c00_0300, inst));
        cyc_begin(1'b1, mk_in(32'h0000_6000, 1'b1, 1'b1, 5'd9, 32'h1c00_0300, inst), 32'h0, 1'b1);
        cyc_end();
        cyc_begin(1'b0, '0, 32'h1111_2222, 1'b0);
        cyc_end();
        cyc_begin(1'b0, '0, 32'h5555_6666, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        sb_q.delete();
        n_total += 3;
        if (MEM_allow_in !== 1'b1) $display("FAIL arst_allow_in: got %b required 1", MEM_allow_in);
        else n_pass++;
        if (MEM_to_WB_valid !== 1'b0) $display("FAIL arst_valid: got %b required 0", MEM_to_WB_valid);
        else n_pass++;
        if (MEM_wr_bus !== 38'h0) $display("FAIL arst_wr_bus: got %h required 0", MEM_wr_bus);
        else n_pass++;
        #1;
        resetn = 1'b1;
        cyc_end();
        sb_q.push_back(mk_out(32'h3333_4444, 1'b1, 5'd10, 32'h1c00_0304, inst));
        cyc_begin(1'b1, mk_in(32'h0000_6004, 1'b1, 1'b1, 5'd10, 32'h1c00_0304, inst), 32'h0, 1'b1);
        cyc_end();
        cyc_begin(1'b0, '0, 32'h3333_4444, 1'b1);
        cyc_end();
        cyc_begin(1'b0, '0, 32'h0, 1'b1);
        cyc_end();
    endtask

    initial begin
        test_reset();
        test_back_to_back_loads();
        test_wb_stall();
        test_alu_forward();
        test_reset_mid_stall();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
